// File: rtl/memoria_resultados.sv
// memoria_resultados
// Result write-back RAM with a sweep sequencer. A start pulse walks addr_o
// from 0 to LAST_ADDR, one address per cycle. The ALU result returned for
// each address is stored in the RAM, then done_o pulses for one cycle.
// The RAM also has a registered read port and a direct write port. The
// direct write port is locked out while a sweep owns the RAM.
module memoria_resultados #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int LAST_ADDR = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] resultado_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_err_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Last sweep address at port width. Keeping it at ADDR_W bits makes the
  // end-of-sweep compare width-exact, so addr_o never wraps.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              wr_err_reg, wr_err_next;
  logic [DATA_W-1:0] rd_data_reg;

  // The RAM has one write port, shared by the sweep and the direct port.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // The storage array has no reset, so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  // State, operand address and error flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wr_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      wr_err_reg <= wr_err_next;
    end
  end

  // Next-state logic, address stepping and the direct-write lockout flag
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    wr_err_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // start_i is only sampled here. A start seen in SWEEP or FIN is
        // dropped and is not remembered.
        if (start_i) begin
          addr_next  = '0;
          state_next = SWEEP;
        end
      end

      SWEEP: begin
        // The RAM belongs to the sweep, so a direct write is refused and
        // the refusal is flagged for one cycle.
        wr_err_next = wr_en_i;
        if (addr_reg == LAST) begin
          state_next = FIN;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end

      FIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write-port arbitration: during a sweep the RAM captures the ALU result;
  // otherwise it takes the direct write. If start and a direct write arrive
  // on the same IDLE edge, the direct write lands now. The sweep overwrites
  // that entry later if its address is in the sweep range.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (state_reg == SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = addr_reg;
      mem_wdata = resultado_i;
    end else if (wr_en_i) begin
      mem_we = 1'b1;
    end
  end

  // RAM write port
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port. A read and a write to the same address on the
  // same edge return the old word. Only this output register is cleared by
  // reset; the array contents are not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr_i];
    end
  end

  // Status outputs are decoded straight from the state register, so they
  // cannot glitch.
  assign busy_o    = (state_reg == SWEEP);
  assign done_o    = (state_reg == FIN);
  assign addr_o    = addr_reg;
  assign wr_err_o  = wr_err_reg;
  assign rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_memoria_resultados.sv
// Directed testbench for memoria_resultados. Inputs change 1 ns after a
// rising edge, and outputs are sampled at that same point.
module tb_memoria_resultados;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] resultado_i;
  logic              busy_o;
  logic              done_o;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_err_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;

  logic [DATA_W-1:0] res_base;

  int checks = 0;
  int errors = 0;

  // Stand-in for the ALU: the result depends only on addr_o.
  assign resultado_i = res_base + {{(DATA_W-ADDR_W){1'b0}}, addr_o};

  always #5 clk_i = ~clk_i;

  memoria_resultados #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAST_ADDR(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .addr_o      (addr_o),
    .resultado_i (resultado_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .wr_err_o    (wr_err_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    checks++;
    if ({addr_o, busy_o, done_o, wr_err_o} !== 6'b0 || rd_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d busy=%b done=%b err=%b rd=%h, expected all zero",
               addr_o, busy_o, done_o, wr_err_o, rd_data_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_sweep();
    logic [ADDR_W-1:0] exp_addr [4];
    logic              exp_busy [4];
    logic              exp_done [4];
    logic [DATA_W-1:0] exp_mem  [3];
    int                done_cnt;
    exp_addr = '{3'd0, 3'd1, 3'd2, 3'd2};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_mem  = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002};
    done_cnt = 0;
    res_base = 32'hA5A5_0000;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_o) done_cnt++;
      checks++;
      if (addr_o !== exp_addr[i] || busy_o !== exp_busy[i] || done_o !== exp_done[i]) begin
        errors++;
        $display("FAIL sweep_cycle%0d: addr=%0d busy=%b done=%b, expected addr=%0d busy=%b done=%b",
                 i, addr_o, busy_o, done_o, exp_addr[i], exp_busy[i], exp_done[i]);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (done_o) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL sweep_done_count: got %0d pulses, expected 1", done_cnt);
    end
    for (int a = 0; a < 3; a++) begin
      rd_addr_i = ADDR_W'(a);
      tick();
      checks++;
      if (rd_data_o !== exp_mem[a]) begin
        errors++;
        $display("FAIL sweep_mem%0d: got %h expected %h", a, rd_data_o, exp_mem[a]);
      end
    end
    $display("sweep: addr sequence, done pulse and mem[0..2] checked");
  endtask

  task automatic test_write_during_sweep();
    wr_en_i = 1'b1; wr_addr_i = 3'd5; wr_data_i = 32'h5555_5555;
    tick();
    wr_en_i = 1'b0;
    checks++;
    if (wr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_write_no_err: got %b expected 0", wr_err_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wr_en_i = 1'b1; wr_addr_i = 3'd5; wr_data_i = 32'hDEAD_BEEF;
    tick();
    wr_en_i = 1'b0;
    checks++;
    if (wr_err_o !== 1'b1) begin
      errors++;
      $display("FAIL sweep_write_err: got %b expected 1", wr_err_o);
    end
    tick();
    checks++;
    if (wr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL sweep_write_err_pulse: got %b expected 0", wr_err_o);
    end
    tick();
    tick();
    rd_addr_i = 3'd5;
    tick();
    checks++;
    if (rd_data_o !== 32'h5555_5555) begin
      errors++;
      $display("FAIL sweep_write_dropped: got %h expected 55555555", rd_data_o);
    end
    $display("write_during_sweep: error pulse and unchanged mem[5] checked");
  endtask

  task automatic test_write_idle();
    wr_en_i = 1'b1; wr_addr_i = 3'd5; wr_data_i = 32'hDEAD_BEEF;
    tick();
    wr_en_i   = 1'b0;
    rd_addr_i = 3'd5;
    checks++;
    if (wr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_write_err: got %b expected 0", wr_err_o);
    end
    tick();
    checks++;
    if (rd_data_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL idle_write_data: got %h expected deadbeef", rd_data_o);
    end
    $display("write_idle: mem[5] readback checked");
  endtask

  task automatic test_read_before_write();
    wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_data_i = 32'h1111_1111;
    tick();
    rd_addr_i = 3'd1; wr_data_i = 32'h2222_2222;
    tick();
    wr_en_i = 1'b0;
    checks++;
    if (rd_data_o !== 32'h1111_1111) begin
      errors++;
      $display("FAIL rbw_old: got %h expected 11111111", rd_data_o);
    end
    tick();
    checks++;
    if (rd_data_o !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rbw_new: got %h expected 22222222", rd_data_o);
    end
    $display("read_before_write: old then new value checked");
  endtask

  task automatic test_reset_mid_sweep();
    logic [DATA_W-1:0] exp_mem [3];
    int                done_cnt;
    exp_mem  = '{32'h7700_0000, 32'h2222_2222, 32'h0000_00F2};
    done_cnt = 0;
    wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 32'h0000_00F0;
    tick();
    wr_addr_i = 3'd2; wr_data_i = 32'h0000_00F2;
    tick();
    wr_en_i  = 1'b0;
    res_base = 32'h7700_0000;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({addr_o, busy_o, done_o, wr_err_o} !== 6'b0 || rd_data_o !== 32'h0) begin
      errors++;
      $display("FAIL midsweep_reset_outputs: addr=%0d busy=%b done=%b err=%b rd=%h, expected all zero",
               addr_o, busy_o, done_o, wr_err_o, rd_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o) done_cnt++;
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL midsweep_no_done: got %0d pulses, expected 0", done_cnt);
    end
    for (int a = 0; a < 3; a++) begin
      rd_addr_i = ADDR_W'(a);
      tick();
      checks++;
      if (rd_data_o !== exp_mem[a]) begin
        errors++;
        $display("FAIL midsweep_mem%0d: got %h expected %h", a, rd_data_o, exp_mem[a]);
      end
    end
    $display("reset_mid_sweep: abort and retained mem checked");
  endtask

  task automatic test_back_to_back();
    // One full period with start_i held high is S,S,S,F,I; it then repeats.
    logic exp_busy [10];
    logic exp_done [10];
    exp_busy = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    exp_done = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    res_base = 32'hA5A5_0000;
    start_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (busy_o !== exp_busy[i] || done_o !== exp_done[i]) begin
        errors++;
        $display("FAIL back_to_back_cycle%0d: busy=%b done=%b, expected busy=%b done=%b",
                 i, busy_o, done_o, exp_busy[i], exp_done[i]);
      end
    end
    start_i = 1'b0;
    tick();
    tick();
    $display("back_to_back: repeated sweeps with one idle cycle checked");
  endtask

  initial begin
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    rd_addr_i = '0;
    res_base  = '0;
    test_reset();
    test_sweep();
    test_write_during_sweep();
    test_write_idle();
    test_read_before_write();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
